// File: rtl/data_mem_slave.sv
// Word-organised data RAM behind a valid/ready slave port.
// Accesses complete after WAIT_STATES extra cycles. Out-of-range accesses
// return an error pulse and leave memory untouched.
module data_mem_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH) - 33'd1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_DONE
  } state_t;

  state_t        state;
  logic [31:0]   ram [DEPTH];

  logic [AW-1:0] cap_idx;
  logic [31:0]   cap_wdata;
  logic [3:0]    cap_wstrb;
  logic          cap_in_range;
  logic [3:0]    wait_cnt;

  logic [AW-1:0] in_idx;
  logic          in_range;
  logic [AW-1:0] rd_idx;
  logic          rd_in_range;
  logic          rd_hit;
  logic          go_resp;

  // Decode the incoming address and pick the request that feeds the RESP entry.
  // With zero wait states RESP is entered straight from IDLE, so the live
  // request is used there instead of the captured copy.
  always_comb begin
    in_idx      = AW'((mem_addr_i - BASE_ADDR) >> 2);
    in_range    = (mem_addr_i >= BASE_ADDR) && ({1'b0, mem_addr_i} <= LAST_ADDR);
    go_resp     = 1'b0;
    rd_idx      = cap_idx;
    rd_in_range = cap_in_range;
    rd_hit      = cap_in_range && (cap_wstrb == 4'b0000);
    if (state == S_IDLE) begin
      go_resp     = mem_valid_i && (WAIT_STATES == 0);
      rd_idx      = in_idx;
      rd_in_range = in_range;
      rd_hit      = in_range && (mem_wstrb_i == 4'b0000);
    end else if (state == S_WAIT) begin
      go_resp = (wait_cnt == 4'd0);
    end
  end

  // Transaction FSM with registered handshake outputs and read data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      mem_ready_o  <= 1'b0;
      mem_rdata_o  <= '0;
      err_o        <= 1'b0;
      busy_o       <= 1'b0;
      wait_cnt     <= '0;
      cap_idx      <= '0;
      cap_wdata    <= '0;
      cap_wstrb    <= '0;
      cap_in_range <= 1'b0;
    end else begin
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
      err_o       <= 1'b0;
      if (go_resp) begin
        state       <= S_RESP;
        mem_ready_o <= 1'b1;
        err_o       <= !rd_in_range;
        mem_rdata_o <= rd_hit ? ram[rd_idx] : '0;
      end
      case (state)
        S_IDLE: begin
          if (mem_valid_i) begin
            cap_idx      <= in_idx;
            cap_wdata    <= mem_wdata_i;
            cap_wstrb    <= mem_wstrb_i;
            cap_in_range <= in_range;
            busy_o       <= 1'b1;
            if (WAIT_STATES != 0) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_DONE;
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Byte-strobed write on the edge that ends RESP.
  always_ff @(posedge clk_i) begin
    if (state == S_RESP && cap_in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (cap_wstrb[i]) begin
          ram[cap_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_slave.sv
// Self-checking bench for data_mem_slave: four instances with different wait
// state settings, directed scenarios plus randomized traffic against a
// word-array reference model.
module tb_data_mem_slave;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 1024;

  function automatic int unsigned ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      2:       return 15;
      default: return 4;
    endcase
  endfunction

  logic        clk;
  logic        rst;
  logic        valid [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [3:0]  wstrb [4];
  logic        ready [4];
  logic [31:0] rdata [4];
  logic        err   [4];
  logic        busy  [4];

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [4][DEPTH];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_mem_slave #(
      .DEPTH      (DEPTH),
      .BASE_ADDR  (BASE),
      .WAIT_STATES(ws_of(g))
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .mem_valid_i(valid[g]),
      .mem_addr_i (addr[g]),
      .mem_wdata_i(wdata[g]),
      .mem_wstrb_i(wstrb[g]),
      .mem_ready_o(ready[g]),
      .mem_rdata_o(rdata[g]),
      .err_o      (err[g]),
      .busy_o     (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint lo;
    longint av;
    lo = longint'({32'h0, BASE});
    av = longint'({32'h0, a});
    return (av >= lo) && (av < lo + 4 * longint'(DEPTH));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] res;
    logic [31:0] m;
    res = old;
    for (int i = 0; i < 4; i++) begin
      m = 32'hFF << (8 * i);
      if (st[i]) res = (res & ~m) | (wd & m);
    end
    return res;
  endfunction

  // One master transaction; cyc is the cycle (acceptance = 0) in which ready was seen.
  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output logic er,
                     output int cyc);
    @(negedge clk);
    valid[d] = 1'b1;
    addr[d]  = a;
    wdata[d] = wd;
    wstrb[d] = st;
    @(posedge clk);
    #1;
    cyc = 1;
    check("accept.busy", busy[d], 1'b1);
    addr[d]  = $urandom;
    wdata[d] = $urandom;
    wstrb[d] = 4'($urandom);
    while (!ready[d] && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rd = rdata[d];
    er = err[d];
    valid[d] = 1'b0;
    @(posedge clk);
    #1;
    check("done.ready", ready[d], 1'b0);
    check("done.busy", busy[d], 1'b1);
    check("done.err", err[d], 1'b0);
    check("done.rdata", rdata[d], 32'h0);
    @(posedge clk);
    #1;
    check("idle.busy", busy[d], 1'b0);
  endtask

  // Transaction checked against the reference model, which is then updated.
  task automatic op(input int d, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] st, input string tag, output logic [31:0] rd);
    logic        er;
    int          cyc;
    bit          ok;
    int          i;
    logic [31:0] exp_rd;
    ok = in_rng(a);
    i  = ok ? int'((a - BASE) >> 2) : 0;
    exp_rd = (ok && st == 4'b0000) ? mdl[d][i] : 32'h0;
    txn(d, a, wd, st, rd, er, cyc);
    check({tag, ".lat"}, cyc, ws_of(d) + 1);
    check({tag, ".err"}, er, !ok);
    check({tag, ".rdata"}, rd, exp_rd);
    if (ok && st != 4'b0000) mdl[d][i] = merge(mdl[d][i], wd, st);
  endtask

  // Keep valid high through completion: must not be re-accepted in DONE.
  task automatic hold_test(input int d);
    int first;
    int second;
    first  = 0;
    second = 0;
    @(negedge clk);
    valid[d] = 1'b1;
    addr[d]  = BASE;
    wdata[d] = 32'h0;
    wstrb[d] = 4'b0000;
    @(posedge clk);
    for (int c = 1; c <= 80; c++) begin
      #1;
      if (first != 0 && c == first + 1) begin
        check("hold.done_ready", ready[d], 1'b0);
        check("hold.done_busy", busy[d], 1'b1);
      end
      if (ready[d]) begin
        if (first == 0) first = c;
        else begin
          second = c;
          break;
        end
      end
      @(posedge clk);
    end
    check("hold.first", first, ws_of(d) + 1);
    check("hold.second", second, 2 * ws_of(d) + 4);
    valid[d] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [3:0]  st;
    bit          saw;
    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      valid[d] = 1'b0;
      addr[d]  = '0;
      wdata[d] = '0;
      wstrb[d] = '0;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check("rst.ready", ready[d], 1'b0);
      check("rst.rdata", rdata[d], 32'h0);
      check("rst.err", err[d], 1'b0);
      check("rst.busy", busy[d], 1'b0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle with valid low
    repeat (10) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
        check("idle.ready", ready[d], 1'b0);
        check("idle.busy", busy[d], 1'b0);
      end
    end

    // Full write then read
    op(0, 32'h1000, 32'hDEADBEEF, 4'hF, "wr1000", rd);
    op(0, 32'h1000, 32'h0, 4'h0, "rd1000", rd);
    check("rd1000.const", rd, 32'hDEADBEEF);

    // Byte strobes
    op(0, 32'h1004, 32'h11223344, 4'hF, "pre1004", rd);
    op(0, 32'h1004, 32'hAABBCCDD, 4'b0101, "strb1004", rd);
    op(0, 32'h1004, 32'h0, 4'h0, "rd1004", rd);
    check("rd1004.const", rd, 32'h11BB33DD);

    // Out of range
    op(0, 32'h0FFC, 32'h0, 4'h0, "oor_lo", rd);
    op(0, BASE + 4 * DEPTH, 32'h0, 4'h0, "oor_hi", rd);
    op(0, 32'h0FFC, 32'h55555555, 4'hF, "oor_wr", rd);
    op(0, BASE + 4 * DEPTH, 32'h66666666, 4'hF, "oor_alias_wr", rd);
    op(0, 32'h1000, 32'h0, 4'h0, "rd_word0", rd);
    check("word0.const", rd, 32'hDEADBEEF);

    // Latency sweep and held-valid behaviour
    op(1, 32'h1000, 32'h01020304, 4'hF, "ws0.wr", rd);
    op(1, 32'h1000, 32'h0, 4'h0, "ws0.rd", rd);
    op(2, 32'h1010, 32'hA5A5A5A5, 4'hF, "ws15.wr", rd);
    op(2, 32'h1010, 32'h0, 4'h0, "ws15.rd", rd);
    hold_test(1);
    hold_test(2);

    // Reset during WAIT drops the pending write
    op(3, 32'h1008, 32'hCAFEF00D, 4'hF, "ws4.pre", rd);
    @(negedge clk);
    valid[3] = 1'b1;
    addr[3]  = 32'h1008;
    wdata[3] = 32'h12345678;
    wstrb[3] = 4'hF;
    @(posedge clk);
    #1;
    check("mid.busy", busy[3], 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid.ready", ready[3], 1'b0);
    check("mid.busy0", busy[3], 1'b0);
    check("mid.err", err[3], 1'b0);
    check("mid.rdata", rdata[3], 32'h0);
    @(negedge clk);
    valid[3] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ready[3] || busy[3]) saw = 1'b1;
    end
    check("mid.quiet", saw, 1'b0);
    op(3, 32'h1008, 32'h0, 4'h0, "mid.rd", rd);
    check("mid.rd.const", rd, 32'hCAFEF00D);

    // Randomized traffic on a 16-word window plus out-of-range aliases
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        op(d, BASE + 32'(4 * i), $urandom, 4'hF, "rnd.pre", rd);
      end
      for (int n = 0; n < 150; n++) begin
        case ($urandom_range(0, 9))
          8:       a = BASE - 32'(4 * $urandom_range(1, 64));
          9: begin
            if ($urandom_range(0, 1) == 0) a = BASE + 4 * DEPTH + 32'(4 * $urandom_range(0, 15));
            else a = 32'hFFFF_FFFC;
          end
          default: a = BASE + 32'(4 * $urandom_range(0, 15));
        endcase
        a  = a + 32'($urandom_range(0, 3));
        st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        op(d, a, $urandom, st, "rnd", rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
